// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// channel select and the word size in bytes.
package mem_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_WAIT,
    ST_RESP,
    ST_FAULT
  } state_t;

  typedef enum logic {
    SEL_INSTR = 1'b0,
    SEL_DATA  = 1'b1
  } sel_t;

  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/mem_addr_check.sv
// Combinational legality check for a byte address: word aligned and
// inside [MEM_BASE, MEM_LIMIT].
//   i_addr  : byte address to test
//   o_legal : 1 when the address may be sent to the SRAM
module mem_addr_check
  import mem_pkg::*;
#(
  parameter int              ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 16'h0000,
  parameter logic [ADDR_W-1:0] MEM_LIMIT = 16'h3FFC
) (
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_legal
);
  localparam int LSB = $clog2(WORD_BYTES);

  logic w_aligned, w_ge_base, w_le_limit;

  assign w_aligned = (i_addr[LSB-1:0] == '0);

  // Bounds that sit at the ends of the address space are trivially met;
  // resolving them here keeps constant comparisons out of the netlist.
  if (MEM_BASE == '0) begin : g_base_any
    assign w_ge_base = 1'b1;
  end else begin : g_base_cmp
    assign w_ge_base = (i_addr >= MEM_BASE);
  end

  if (MEM_LIMIT == '1) begin : g_lim_any
    assign w_le_limit = 1'b1;
  end else begin : g_lim_cmp
    assign w_le_limit = (i_addr <= MEM_LIMIT);
  end

  assign o_legal = w_aligned & w_ge_base & w_le_limit;
endmodule

// File: rtl/mem_responder.sv
// Memory-side responder serving an instruction-fetch channel and a data
// load/store channel from one single-port synchronous SRAM (1-cycle read).
// Data has fixed priority. Illegal addresses answer with a 1-cycle segv.
//   clk, reset_n                 : clock, async active-low reset
//   instr_req/addr               : fetch request (held until response)
//   wait_instr/instr_rdata/segv  : fetch handshake and result
//   data_req/we/addr/wdata       : load/store request (held until response)
//   wait_data/data_rdata/segv    : data handshake and result
//   sram_en/we/addr/wdata/rdata  : SRAM macro interface
module mem_responder
  import mem_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] MEM_BASE   = 16'h0000,
  parameter logic [ADDR_W-1:0] MEM_LIMIT  = 16'h3FFC,
  parameter int                EXTRA_WAIT = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_req,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              wait_instr,
  output logic [DATA_W-1:0] instr_rdata,
  output logic              instr_segv,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              wait_data,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_segv,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam int  LSB      = $clog2(WORD_BYTES);
  localparam int  CW       = (EXTRA_WAIT < 2) ? 1 : $clog2(EXTRA_WAIT + 1);
  localparam logic HAS_WAIT = (EXTRA_WAIT != 0);

  state_t                r_state, w_next;
  sel_t                  r_sel, w_sel_req;
  logic [ADDR_W-LSB-1:0] r_waddr;
  logic                  r_we;
  logic [DATA_W-1:0]     r_wdata;
  logic [CW-1:0]         r_cnt;
  logic [DATA_W-1:0]     r_irdata, r_drdata;
  logic                  r_isegv, r_dsegv;

  logic              w_req_any, w_legal, w_done, w_accept;
  logic [ADDR_W-1:0] w_req_addr;

  assign w_req_any  = data_req | instr_req;
  assign w_sel_req  = data_req ? SEL_DATA : SEL_INSTR;
  assign w_req_addr = data_req ? data_addr : instr_addr;
  assign w_accept   = (r_state == ST_IDLE) & w_req_any;

  mem_addr_check #(
    .ADDR_W   (ADDR_W),
    .MEM_BASE (MEM_BASE),
    .MEM_LIMIT(MEM_LIMIT)
  ) u_chk (
    .i_addr (w_req_addr),
    .o_legal(w_legal)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_done     = (r_state == ST_RESP) | (r_state == ST_FAULT);
    // Only the selected channel completes; the other keeps waiting.
    wait_instr = instr_req & ~(w_done & (r_sel == SEL_INSTR));
    wait_data  = data_req  & ~(w_done & (r_sel == SEL_DATA));
    sram_en    = (r_state == ST_ISSUE);
    sram_we    = (r_state == ST_ISSUE) & r_we;
    sram_addr  = r_waddr;
    sram_wdata = r_wdata;
    unique case (r_state)
      ST_IDLE:    if (w_req_any) w_next = w_legal ? ST_ISSUE : ST_FAULT;
      ST_ISSUE:   w_next = ST_CAPTURE;
      ST_CAPTURE: w_next = HAS_WAIT ? ST_WAIT : ST_RESP;
      ST_WAIT:    if (r_cnt == CW'(1)) w_next = ST_RESP;
      ST_RESP:    w_next = ST_IDLE;
      ST_FAULT:   w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel    <= SEL_INSTR;
      r_waddr  <= '0;
      r_we     <= 1'b0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
      r_isegv  <= 1'b0;
      r_dsegv  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel   <= w_sel_req;
        r_waddr <= w_req_addr[ADDR_W-1:LSB];
        r_we    <= data_req & data_we;
        r_wdata <= data_req ? data_wdata : '0;
      end
      if (r_state == ST_ISSUE)     r_cnt <= CW'(EXTRA_WAIT);
      else if (r_state == ST_WAIT) r_cnt <= r_cnt - 1'b1;
      // Load data is captured even if the requester has since dropped.
      if ((r_state == ST_CAPTURE) && !r_we) begin
        if (r_sel == SEL_DATA) r_drdata <= sram_rdata;
        else                   r_irdata <= sram_rdata;
      end
      // segv is high exactly in the FAULT cycle that follows a rejected IDLE.
      r_isegv <= w_accept & ~w_legal & (w_sel_req == SEL_INSTR);
      r_dsegv <= w_accept & ~w_legal & (w_sel_req == SEL_DATA);
    end
  end

  assign instr_rdata = r_irdata;
  assign data_rdata  = r_drdata;
  assign instr_segv  = r_isegv;
  assign data_segv   = r_dsegv;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (EXTRA_WAIT 0 and 2), each with its
// own SRAM model, checked every cycle against a transaction-level model.
module tb_mem_responder;
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wd;
  } req_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [2];
  logic        ireq  [2];
  logic [15:0] iaddr [2];
  logic        dreq  [2];
  logic        dwe   [2];
  logic [15:0] daddr [2];
  logic [31:0] dwdata[2];
  logic        wi[2], wd[2], si[2], sd[2];
  logic [31:0] ird[2], drd[2];
  logic        sen[2], swe[2];
  logic [13:0] sadr[2];
  logic [31:0] swd[2];
  logic [31:0] srd0 = '0, srd1 = '0;
  logic [31:0] sram0 [16384];
  logic [31:0] sram1 [16384];

  logic        bd_en = 1'b0;
  logic [13:0] bd_addr = '0;
  logic [31:0] bd_data = '0;

  mem_responder #(.EXTRA_WAIT(0)) u_dut0 (
    .clk(clk), .reset_n(rst_n[0]),
    .instr_req(ireq[0]), .instr_addr(iaddr[0]), .wait_instr(wi[0]),
    .instr_rdata(ird[0]), .instr_segv(si[0]),
    .data_req(dreq[0]), .data_we(dwe[0]), .data_addr(daddr[0]),
    .data_wdata(dwdata[0]), .wait_data(wd[0]), .data_rdata(drd[0]),
    .data_segv(sd[0]), .sram_en(sen[0]), .sram_we(swe[0]),
    .sram_addr(sadr[0]), .sram_wdata(swd[0]), .sram_rdata(srd0));

  mem_responder #(.EXTRA_WAIT(2)) u_dut2 (
    .clk(clk), .reset_n(rst_n[1]),
    .instr_req(ireq[1]), .instr_addr(iaddr[1]), .wait_instr(wi[1]),
    .instr_rdata(ird[1]), .instr_segv(si[1]),
    .data_req(dreq[1]), .data_we(dwe[1]), .data_addr(daddr[1]),
    .data_wdata(dwdata[1]), .wait_data(wd[1]), .data_rdata(drd[1]),
    .data_segv(sd[1]), .sram_en(sen[1]), .sram_we(swe[1]),
    .sram_addr(sadr[1]), .sram_wdata(swd[1]), .sram_rdata(srd1));

  always @(posedge clk) begin
    if (bd_en) sram0[bd_addr] <= bd_data;
    else if (sen[0]) begin
      if (swe[0]) sram0[sadr[0]] <= swd[0];
      else        srd0 <= sram0[sadr[0]];
    end
  end

  always @(posedge clk) begin
    if (bd_en) sram1[bd_addr] <= bd_data;
    else if (sen[1]) begin
      if (swe[1]) sram1[sadr[1]] <= swd[1];
      else        srd1 <= sram1[sadr[1]];
    end
  end

  // ---------------- model state ----------------
  int          total = 0, bad = 0, cyc = 0;
  logic        rst_drive = 1'b0;
  req_t        iq[2][$];
  req_t        dq[2][$];
  logic [31:0] m_mem [2][65];
  bit          busy[2], msel[2], mfault[2], mwe[2], cap_pend[2];
  bit          resp_i[2], resp_d[2];
  logic [15:0] maddr[2];
  logic [31:0] mwd[2], cap_val[2], e_ird[2], e_drd[2];
  int          acc_at[2], resp_at[2], cap_at[2];
  int          wc_i[2], wc_d[2], last_wi[2], last_wd[2], n_en[2];
  logic        last_si[2], last_sd[2];

  function automatic int ew(input int h);
    return 2 * h;
  endfunction

  // Model memory holds words 0..63 plus the top legal word.
  function automatic int idx(input logic [15:0] a);
    if (a[15:2] == 14'hFFF) return 64;
    return int'(a[7:2]);
  endfunction

  function automatic logic [15:0] raddr();
    int k;
    logic [15:0] a;
    k = $urandom_range(0, 9);
    a = 16'($urandom_range(0, 63)) << 2;
    if (k == 7) a = 16'h3FFC;
    else if (k == 8) begin
      case ($urandom_range(0, 2))
        0:       a = 16'h4000;
        1:       a = 16'hFFFC;
        default: a = 16'h3FFE;
      endcase
    end else if (k == 9) a = a | 16'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic chk(input int h, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", nm, h, cyc, act, exp);
    end
  endtask

  task automatic accept(input int h, input bit dsel, input logic we,
                        input logic [15:0] a, input logic [31:0] wdat);
    int  ai;
    bit  legal;
    ai = int'(a);
    legal = (ai % 4 == 0) && (ai <= 16380);
    busy[h] = 1; msel[h] = dsel; mwe[h] = we; maddr[h] = a; mwd[h] = wdat;
    mfault[h] = !legal; acc_at[h] = cyc;
    resp_at[h] = cyc + (legal ? 3 + ew(h) : 1);
  endtask

  // One cycle of the reference: compare DUT outputs, then advance.
  task automatic step(input int h);
    logic e_wi, e_wd, e_si, e_sd, e_en, e_we;
    bit   was, resp;
    resp_i[h] = 0; resp_d[h] = 0;
    if (sen[h]) n_en[h]++;
    if (!rst_n[h]) begin
      busy[h] = 0; cap_pend[h] = 0; e_ird[h] = 0; e_drd[h] = 0;
      wc_i[h] = 0; wc_d[h] = 0;
      chk(h, "rst_wait_i", 32'(wi[h]), 32'(ireq[h]));
      chk(h, "rst_wait_d", 32'(wd[h]), 32'(dreq[h]));
      chk(h, "rst_segv_i", 32'(si[h]), 0);
      chk(h, "rst_segv_d", 32'(sd[h]), 0);
      chk(h, "rst_rdata_i", ird[h], 0);
      chk(h, "rst_rdata_d", drd[h], 0);
      chk(h, "rst_sram_en", 32'(sen[h]), 0);
      return;
    end
    if (cap_pend[h] && cyc == cap_at[h]) begin
      if (msel[h]) e_drd[h] = cap_val[h];
      else         e_ird[h] = cap_val[h];
      cap_pend[h] = 0;
    end
    was = busy[h]; resp = 0;
    e_wi = ireq[h]; e_wd = dreq[h]; e_si = 0; e_sd = 0; e_en = 0; e_we = 0;
    if (was && cyc == resp_at[h]) begin
      resp = 1;
      if (msel[h]) begin e_wd = 0; e_sd = mfault[h]; end
      else         begin e_wi = 0; e_si = mfault[h]; end
    end
    if (was && !mfault[h] && cyc == acc_at[h] + 1) begin
      e_en = 1; e_we = mwe[h];
    end
    chk(h, "wait_i", 32'(wi[h]), 32'(e_wi));
    chk(h, "wait_d", 32'(wd[h]), 32'(e_wd));
    chk(h, "segv_i", 32'(si[h]), 32'(e_si));
    chk(h, "segv_d", 32'(sd[h]), 32'(e_sd));
    chk(h, "rdata_i", ird[h], e_ird[h]);
    chk(h, "rdata_d", drd[h], e_drd[h]);
    chk(h, "sram_en", 32'(sen[h]), 32'(e_en));
    chk(h, "sram_we", 32'(swe[h]), 32'(e_we));
    if (e_en) begin
      chk(h, "sram_addr", 32'(sadr[h]), 32'(maddr[h] >> 2));
      if (mwe[h]) begin
        chk(h, "sram_wdata", swd[h], mwd[h]);
        m_mem[h][idx(maddr[h])] = mwd[h];
      end else begin
        cap_val[h] = m_mem[h][idx(maddr[h])];
        cap_pend[h] = 1; cap_at[h] = cyc + 2;
      end
    end
    if (resp && !msel[h]) begin last_wi[h] = wc_i[h]; last_si[h] = si[h]; wc_i[h] = 0; end
    else if (ireq[h] && wi[h]) wc_i[h]++;
    if (resp && msel[h]) begin last_wd[h] = wc_d[h]; last_sd[h] = sd[h]; wc_d[h] = 0; end
    else if (dreq[h] && wd[h]) wc_d[h]++;
    if (resp) begin
      busy[h] = 0;
      if (msel[h]) resp_d[h] = 1; else resp_i[h] = 1;
    end
    if (!was) begin
      if (dreq[h])      accept(h, 1, dwe[h], daddr[h], dwdata[h]);
      else if (ireq[h]) accept(h, 0, 1'b0, iaddr[h], 32'h0);
    end
  endtask

  task automatic cycle();
    req_t r;
    @(posedge clk);
    #1;
    for (int h = 0; h < 2; h++) begin
      rst_n[h] = rst_drive;
      if (ireq[h] && resp_i[h]) ireq[h] = 1'b0;
      if (dreq[h] && resp_d[h]) dreq[h] = 1'b0;
      if (!ireq[h] && iq[h].size() > 0) begin
        r = iq[h].pop_front();
        ireq[h] = 1'b1; iaddr[h] = r.addr;
      end
      if (!dreq[h] && dq[h].size() > 0) begin
        r = dq[h].pop_front();
        dreq[h] = 1'b1; dwe[h] = r.we; daddr[h] = r.addr; dwdata[h] = r.wd;
      end
    end
    @(negedge clk);
    for (int h = 0; h < 2; h++) step(h);
    cyc++;
  endtask

  function automatic bit all_idle();
    for (int h = 0; h < 2; h++)
      if (busy[h] || iq[h].size() != 0 || dq[h].size() != 0 || ireq[h] || dreq[h])
        return 0;
    return 1;
  endfunction

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin cycle(); n++; end while (!all_idle() && n < 300);
    chk(0, {nm, "_timeout"}, 32'(all_idle()), 1);
  endtask

  task automatic push_d(input logic we, input logic [15:0] a, input logic [31:0] v);
    for (int h = 0; h < 2; h++) dq[h].push_back('{we, a, v});
  endtask

  initial begin
    int snap[2];
    int n;
    logic [31:0] v;
    for (int h = 0; h < 2; h++) begin
      rst_n[h] = 1'b0; ireq[h] = 0; iaddr[h] = 0; dreq[h] = 0; dwe[h] = 0;
      daddr[h] = 0; dwdata[h] = 0; busy[h] = 0; cap_pend[h] = 0;
      resp_i[h] = 0; resp_d[h] = 0; e_ird[h] = 0; e_drd[h] = 0;
      wc_i[h] = 0; wc_d[h] = 0; last_wi[h] = 0; last_wd[h] = 0; n_en[h] = 0;
      last_si[h] = 0; last_sd[h] = 0;
    end
    // Preload both SRAMs and the model while in reset.
    for (int w = 0; w < 65; w++) begin
      v = (w == 16) ? 32'hDEADBEEF : $urandom;
      bd_en = 1'b1; bd_addr = (w == 64) ? 14'hFFF : 14'(w); bd_data = v;
      for (int h = 0; h < 2; h++) m_mem[h][w] = v;
      cycle();
    end
    bd_en = 1'b0;
    cycle();
    rst_drive = 1'b1;
    cycle();

    // Fetch of word 0x10.
    for (int h = 0; h < 2; h++) iq[h].push_back('{1'b0, 16'h0040, 32'h0});
    wait_done("t1");
    for (int h = 0; h < 2; h++) begin
      chk(h, "t1_wait_cycles", 32'(last_wi[h]), (h == 0) ? 3 : 5);
      chk(h, "t1_rdata", ird[h], 32'hDEADBEEF);
      chk(h, "t1_segv", 32'(last_si[h]), 0);
    end

    // Store then load; the store must not disturb data_rdata.
    push_d(1'b0, 16'h0040, 0);
    wait_done("t2a");
    push_d(1'b1, 16'h0080, 32'h12345678);
    wait_done("t2b");
    for (int h = 0; h < 2; h++) chk(h, "t2_store_keeps", drd[h], 32'hDEADBEEF);
    push_d(1'b0, 16'h0080, 0);
    wait_done("t2c");
    for (int h = 0; h < 2; h++) chk(h, "t2_load", drd[h], 32'h12345678);

    // Faults: above limit and misaligned.
    for (int h = 0; h < 2; h++) snap[h] = n_en[h];
    push_d(1'b0, 16'h4000, 0);
    wait_done("t3a");
    for (int h = 0; h < 2; h++) begin
      chk(h, "t3_hi_wait", 32'(last_wd[h]), 1);
      chk(h, "t3_hi_segv", 32'(last_sd[h]), 1);
    end
    push_d(1'b0, 16'h0042, 0);
    wait_done("t3b");
    for (int h = 0; h < 2; h++) begin
      chk(h, "t3_mis_wait", 32'(last_wd[h]), 1);
      chk(h, "t3_mis_segv", 32'(last_sd[h]), 1);
      chk(h, "t3_no_sram", 32'(n_en[h]), 32'(snap[h]));
    end

    // Simultaneous requests: data first, then instr.
    for (int h = 0; h < 2; h++) iq[h].push_back('{1'b0, 16'h0040, 32'h0});
    push_d(1'b0, 16'h0020, 0);
    wait_done("t4");
    for (int h = 0; h < 2; h++) begin
      chk(h, "t4_data_wait", 32'(last_wd[h]), (h == 0) ? 3 : 5);
      chk(h, "t4_instr_wait", 32'(last_wi[h]), (h == 0) ? 7 : 11);
    end

    // Reset during the ISSUE cycle of a store: the write is lost.
    push_d(1'b1, 16'h0080, 32'hCAFEF00D);
    n = 0;
    do begin cycle(); n++; end while (!(busy[0] && busy[1]) && n < 10);
    rst_drive = 1'b0;
    cycle();
    for (int h = 0; h < 2; h++) chk(h, "t6_en_drop", 32'(sen[h]), 0);
    for (int h = 0; h < 2; h++) dreq[h] = 1'b0;
    cycle();
    rst_drive = 1'b1;
    cycle();
    push_d(1'b0, 16'h0080, 0);
    wait_done("t6");
    for (int h = 0; h < 2; h++) chk(h, "t6_store_lost", drd[h], 32'h12345678);

    // Random traffic on both channels.
    for (int t = 0; t < 1500; t++) begin
      for (int h = 0; h < 2; h++) begin
        if (!ireq[h] && iq[h].size() == 0 && $urandom_range(0, 2) == 0)
          iq[h].push_back('{1'b0, raddr(), 32'h0});
        if (!dreq[h] && dq[h].size() == 0 && $urandom_range(0, 2) == 0)
          dq[h].push_back('{1'($urandom_range(0, 1)), raddr(), 32'($urandom)});
      end
      cycle();
    end
    wait_done("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU control path's instruction-fetch and data load/store channels.
- Accepts held-high requests, drives the wait_instr/wait_data handshake, and raises instr_segv/data_segv on out-of-range or misaligned addresses.
- Serves both channels from one single-port synchronous SRAM with 1-cycle read latency; sits between the control path and the memory macro.

Parameters:
- ADDR_W, 16, byte-address width of both request channels.
- DATA_W, 32, word width; accesses are full-word only.
- MEM_BASE, 16'h0000, lowest legal byte address (inclusive, word-aligned).
- MEM_LIMIT, 16'h3FFC, highest legal word byte address (inclusive, word-aligned).
- EXTRA_WAIT, 0, additional wait cycles per SRAM access (0..15).

Ports:
- clk  in  1  clock, all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_req  in  1  fetch request; held high until the response cycle.
- instr_addr  in  ADDR_W  fetch byte address.
- wait_instr  out  1  high while a fetch is requested and not yet completed.
- instr_rdata  out  DATA_W  fetched word.
- instr_segv  out  1  fetch fault; valid in the response cycle.
- data_req  in  1  load/store request; held high until the response cycle.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  ADDR_W  data byte address.
- data_wdata  in  DATA_W  store data.
- wait_data  out  1  high while a data request is pending.
- data_rdata  out  DATA_W  loaded word.
- data_segv  out  1  data fault; valid in the response cycle.
- sram_en  out  1  SRAM enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  ADDR_W-2  SRAM word address (addr[ADDR_W-1:2]).
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  valid the cycle after an enabled read; held until the next enable.

Behaviour:
- States: IDLE, ISSUE, CAPTURE, WAIT, RESP, FAULT.
- Reset: async to IDLE. All outputs 0, except wait_x, which stays combinational (req_x & not completing). The latched address, write enable, write data and channel select are cleared. sram_en drops immediately, so an in-flight write may be lost.
- IDLE: if data_req is high, select the data channel; else if instr_req is high, select instr. Data has fixed priority.
- IDLE, on a selected request: latch addr, we and wdata.
  - Legal address (addr[1:0]==0, MEM_BASE <= addr <= MEM_LIMIT): go to ISSUE.
  - Otherwise: go to FAULT.
- ISSUE (1 cycle): sram_en=1, sram_we=latched we, sram_addr and sram_wdata from the latch. Load the wait counter with EXTRA_WAIT. Go to CAPTURE.
- CAPTURE (1 cycle): on a load, register sram_rdata into the selected channel's rdata register. If EXTRA_WAIT==0 go to RESP, else go to WAIT.
- WAIT: decrement the counter; go to RESP when it reaches 1.
- RESP (1 cycle): the selected channel's wait is 0 and its segv is 0; rdata is valid. Return to IDLE.
- FAULT (1 cycle): the selected channel's wait is 0 and its segv is 1. No SRAM access. Return to IDLE.
- wait_x = x_req & ~((state==RESP | state==FAULT) & sel==x). The unselected channel keeps wait high.
- Latency, request first seen in IDLE at cycle N:
  - Good access: response at N+3+EXTRA_WAIT.
  - Fault: response at N+1.
- segv outputs are registered: high only in the FAULT cycle, 0 otherwise.
- rdata registers hold until the next completed load on the same channel. A store never changes data_rdata.
- Request dropped mid-operation: the access still completes (a store is still written) and the response is discarded; go to IDLE.
- Back-to-back: a new request is evaluated in the IDLE cycle after RESP/FAULT. The minimum gap between responses is therefore 1 IDLE cycle.
- Counter width: max(1, clog2(EXTRA_WAIT+1)).

Decomposition:
- Package mem_pkg holds:
  - the state encoding;
  - the channel-select enum (SEL_INSTR, SEL_DATA);
  - WORD_BYTES=4.
- Sub-module mem_addr_check: combinational legal/aligned check on an address, parameterised by MEM_BASE and MEM_LIMIT.
- Arbitration and the FSM live in the top module.

Test Plan:
1. EXTRA_WAIT=0, SRAM word 0x10 preloaded with 32'hDEADBEEF; instr_req with addr 0x40 at cycle N -> wait_instr high in N..N+2, low at N+3, instr_rdata=32'hDEADBEEF, instr_segv=0.
2. Store 32'h12345678 to 0x80, then load 0x80 -> sram_we=1 only in the store's ISSUE cycle; the load returns 32'h12345678; data_rdata is unchanged by the store.
3. data_req load at 0x4000 (above MEM_LIMIT), and separately at 0x0042 (misaligned) -> wait_data low at N+1, data_segv=1 for that 1 cycle, sram_en never asserted.
4. instr_req and data_req rise in the same cycle -> data is served first (response at N+3). instr is accepted at N+4 and responds at N+7. wait_instr stays high throughout until then.
5. EXTRA_WAIT=2, load at 0x20 -> response at N+5. wait_data is high in exactly 5 cycles.
6. reset_n low during ISSUE of a store -> sram_en falls immediately, state is IDLE, all rdata and segv are 0. After release, a fresh load completes normally.
